// File: rtl/qspi_latency_model_if.sv
// QSPI latency model bus: config, selects and data in; delayed data, valid and status out.
// master drives latency_cfg/select_n/data_in; slave returns data_out/valid_out/latency_active/cfg_*.
interface qspi_latency_model_if #(
  parameter int DATA_WIDTH  = 4,
  parameter int MAX_LATENCY = 3,
  parameter int NUM_SELECTS = 3,
  parameter int LAT_W       = $clog2(MAX_LATENCY + 2)
);
  logic [LAT_W-1:0]       latency_cfg;
  logic [NUM_SELECTS-1:0] select_n;
  logic [DATA_WIDTH-1:0]  data_in;
  logic [DATA_WIDTH-1:0]  data_out;
  logic                   valid_out;
  logic [LAT_W-1:0]       latency_active;
  logic                   cfg_pending;
  logic                   cfg_range_err;

  modport master (
    output latency_cfg, select_n, data_in,
    input  data_out, valid_out, latency_active,
    input  cfg_pending, cfg_range_err
  );

  modport slave (
    input  latency_cfg, select_n, data_in,
    output data_out, valid_out, latency_active,
    output cfg_pending, cfg_range_err
  );
endinterface

// File: rtl/qspi_latency_model.sv
// Delay line for QSPI read data: 0..MAX_LATENCY cycles, latency changed only while the bus is idle.
// Ports: clk, rst_n (sync, active low), bus (slave modport of qspi_latency_model_if).
module qspi_latency_model #(
  parameter int DATA_WIDTH  = 4,
  parameter int MAX_LATENCY = 3,
  parameter int NUM_SELECTS = 3,
  parameter int LAT_W       = $clog2(MAX_LATENCY + 2)
) (
  input logic                 clk,
  input logic                 rst_n,
  qspi_latency_model_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } state_e;

  typedef struct packed {
    logic                  v;
    logic [DATA_WIDTH-1:0] d;
  } stage_t;

  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LATENCY);
  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

  stage_t [MAX_LATENCY-1:0] pipe_q, pipe_d;
  state_e                   state_q, state_d;
  logic [LAT_W-1:0]         lat_q, lat_d;
  logic [LAT_W-1:0]         cnt_q, cnt_d;
  logic                     err_q, err_d;

  logic                  sel_any;
  logic                  cfg_oor;
  logic [LAT_W-1:0]      eff_cfg;
  logic                  out_v;
  logic [DATA_WIDTH-1:0] out_d;

  assign sel_any = ~&bus.select_n;
  assign cfg_oor = bus.latency_cfg > LAT_MAX;
  assign eff_cfg = cfg_oor ? LAT_MAX : bus.latency_cfg;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = {sel_any, bus.data_in};
    for (int i = 1; i < MAX_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Latency only follows the config while idle, so a
  // transaction never sees its delay change under it.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
    err_d   = err_q | cfg_oor;
    unique case (state_q)
      IDLE: begin
        lat_d = eff_cfg;
        if (sel_any) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!sel_any) begin
          if (lat_q != '0) begin
            state_d = DRAIN;
            cnt_d   = lat_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (sel_any) begin
          state_d = ACTIVE;
        end else if (cnt_q == LAT_ONE) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - LAT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latency 0 bypasses the pipeline entirely.
  always_comb begin
    out_v = sel_any;
    out_d = bus.data_in;
    for (int i = 0; i < MAX_LATENCY; i++) begin
      if (lat_q == LAT_W'(i + 1)) begin
        out_v = pipe_q[i].v;
        out_d = pipe_q[i].d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_q  <= '0;
      state_q <= IDLE;
      lat_q   <= eff_cfg;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      pipe_q  <= pipe_d;
      state_q <= state_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.valid_out      = out_v;
  assign bus.data_out       = out_v ? out_d : '0;
  assign bus.latency_active = lat_q;
  assign bus.cfg_pending    = eff_cfg != lat_q;
  assign bus.cfg_range_err  = err_q;

endmodule

// File: tb/tb_qspi_latency_model.sv
// Bench for qspi_latency_model: directed vectors, literal checks and a per-cycle history model.
// Drives the master side of qspi_latency_model_if; prints one Result line.
module tb_qspi_latency_model;

  localparam int DW = 4;
  localparam int ML = 3;
  localparam int NS = 3;
  localparam int LW = $clog2(ML + 2);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int errors = 0;
  int checks = 0;

  qspi_latency_model_if #(
    .DATA_WIDTH(DW), .MAX_LATENCY(ML),
    .NUM_SELECTS(NS), .LAT_W(LW)
  ) bus ();

  qspi_latency_model #(
    .DATA_WIDTH(DW), .MAX_LATENCY(ML),
    .NUM_SELECTS(NS), .LAT_W(LW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int effc(input int c);
    return (c > ML) ? ML : c;
  endfunction

  // Model: hist[k] is the {valid,data} seen k cycles ago.
  // The bus counts as idle once the last select-low cycle
  // is more than latency+1 cycles in the past.
  logic [DW:0] hist [0:ML];
  int          m_lat;
  int          since_low;
  bit          m_err;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k <= ML; k++) hist[k] = '0;
      m_lat     = effc(int'(bus.latency_cfg));
      m_err     = 1'b0;
      since_low = 1000;
    end else begin
      if (since_low > m_lat + 1)
        m_lat = effc(int'(bus.latency_cfg));
      if (int'(bus.latency_cfg) > ML) m_err = 1'b1;
      for (int k = ML; k >= 2; k--) hist[k] = hist[k-1];
      hist[1] = {~&bus.select_n, bus.data_in};
      if (~&bus.select_n) since_low = 1;
      else if (since_low < 1000) since_low++;
    end
  end

  always @(negedge clk) begin
    logic          ev;
    logic [DW-1:0] ed;
    if (rst_n) begin
      if (m_lat == 0) begin
        ev = ~&bus.select_n;
        ed = bus.data_in;
      end else begin
        ev = hist[m_lat][DW];
        ed = hist[m_lat][DW-1:0];
      end
      if (!ev) ed = '0;
      chk("m_valid", 32'(bus.valid_out), 32'(ev));
      chk("m_data", 32'(bus.data_out), 32'(ed));
      chk("m_lat", 32'(bus.latency_active), 32'(m_lat));
      chk("m_pend", 32'(bus.cfg_pending),
          32'(effc(int'(bus.latency_cfg)) != m_lat));
      chk("m_err", 32'(bus.cfg_range_err), 32'(m_err));
    end
  end

  // Advance one cycle: inputs change just after the edge,
  // outputs are read at the following falling edge.
  task automatic cyc(input logic [LW-1:0] c,
                     input logic [NS-1:0] s,
                     input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    bus.latency_cfg = c;
    bus.select_n    = s;
    bus.data_in     = d;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [LW-1:0] c;
    logic [NS-1:0] s;
    logic [DW-1:0] d;
  } vec_t;

  vec_t tail [16];

  initial begin
    bus.latency_cfg = 3'd2;
    bus.select_n    = 3'b111;
    bus.data_in     = '0;
    cyc(2, 3'b111, 0);
    cyc(2, 3'b111, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t1_strap", 32'(bus.latency_active), 2);
    chk("t1_err0", 32'(bus.cfg_range_err), 0);

    // 1: two-cycle delay of a single beat
    cyc(2, 3'b110, 4'hA);
    chk("t1_v0", 32'(bus.valid_out), 0);
    cyc(2, 3'b111, 0);
    chk("t1_v1", 32'(bus.valid_out), 0);
    cyc(2, 3'b111, 0);
    chk("t1_d2", 32'(bus.data_out), 32'hA);
    chk("t1_v2", 32'(bus.valid_out), 1);

    // 2: zero latency passes through, zero when deselected
    cyc(0, 3'b111, 0);
    chk("t2_pend", 32'(bus.cfg_pending), 1);
    cyc(0, 3'b111, 0);
    cyc(0, 3'b111, 0);
    chk("t2_lat0", 32'(bus.latency_active), 0);
    cyc(0, 3'b101, 4'h5);
    chk("t2_d5", 32'(bus.data_out), 5);
    chk("t2_v5", 32'(bus.valid_out), 1);
    cyc(0, 3'b011, 4'h9);
    chk("t2_d9", 32'(bus.data_out), 9);
    cyc(0, 3'b111, 4'hF);
    chk("t2_dz", 32'(bus.data_out), 0);
    chk("t2_vz", 32'(bus.valid_out), 0);

    // 3: cfg change mid-transaction held through drain
    cyc(3, 3'b111, 0);
    cyc(3, 3'b111, 0);
    chk("t3_lat3", 32'(bus.latency_active), 3);
    cyc(3, 3'b110, 1);
    cyc(3, 3'b110, 2);
    cyc(1, 3'b110, 3);
    chk("t3_pend", 32'(bus.cfg_pending), 1);
    chk("t3_hold", 32'(bus.latency_active), 3);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 3'b111, 0);
      chk("t3_drain_lat", 32'(bus.latency_active), 3);
      chk("t3_drain_pend", 32'(bus.cfg_pending), 1);
      chk("t3_drain_d", 32'(bus.data_out),
          32'((i < 3) ? i + 1 : 0));
    end
    cyc(1, 3'b111, 0);
    chk("t3_lat1", 32'(bus.latency_active), 1);
    chk("t3_pend0", 32'(bus.cfg_pending), 0);

    // 4: clamp and sticky range error
    cyc(7, 3'b111, 0);
    chk("t4_pend", 32'(bus.cfg_pending), 1);
    chk("t4_err0", 32'(bus.cfg_range_err), 0);
    cyc(7, 3'b111, 0);
    chk("t4_clamp", 32'(bus.latency_active), 3);
    chk("t4_err1", 32'(bus.cfg_range_err), 1);
    cyc(2, 3'b111, 0);
    chk("t4_pend2", 32'(bus.cfg_pending), 1);
    cyc(2, 3'b111, 0);
    chk("t4_lat2", 32'(bus.latency_active), 2);
    chk("t4_sticky", 32'(bus.cfg_range_err), 1);

    // 5: reselect during drain keeps latency and stream
    cyc(2, 3'b110, 1);
    cyc(3, 3'b110, 2);
    chk("t5_pend", 32'(bus.cfg_pending), 1);
    cyc(3, 3'b111, 0);
    chk("t5_d1", 32'(bus.data_out), 1);
    cyc(3, 3'b101, 3);
    chk("t5_d2", 32'(bus.data_out), 2);
    chk("t5_lat", 32'(bus.latency_active), 2);
    cyc(3, 3'b101, 4);
    chk("t5_gap", 32'(bus.valid_out), 0);
    cyc(3, 3'b111, 0);
    chk("t5_d3", 32'(bus.data_out), 3);
    cyc(3, 3'b111, 0);
    chk("t5_d4", 32'(bus.data_out), 4);
    chk("t5_lat2", 32'(bus.latency_active), 2);
    cyc(3, 3'b111, 0);
    chk("t5_end", 32'(bus.valid_out), 0);
    cyc(3, 3'b111, 0);
    chk("t5_idle_lat", 32'(bus.latency_active), 2);
    cyc(3, 3'b111, 0);
    chk("t5_new_lat", 32'(bus.latency_active), 3);

    // 6: reset mid-transaction flushes in-flight beats
    cyc(3, 3'b110, 7);
    cyc(3, 3'b110, 8);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.select_n = 3'b101;
    bus.data_in  = 4'h9;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.select_n = 3'b111;
    bus.data_in  = 0;
    @(negedge clk);
    chk("t6_lat", 32'(bus.latency_active), 3);
    chk("t6_v", 32'(bus.valid_out), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(3, 3'b111, 0);
      chk("t6_flush_v", 32'(bus.valid_out), 0);
      chk("t6_flush_d", 32'(bus.data_out), 0);
    end

    // Mixed tail: latency changes across short bursts.
    tail = '{
      '{1, 3'b110, 4'h1}, '{1, 3'b110, 4'h2},
      '{0, 3'b111, 4'h3}, '{0, 3'b011, 4'h4},
      '{0, 3'b111, 4'h5}, '{0, 3'b111, 4'h6},
      '{0, 3'b111, 4'h7}, '{0, 3'b110, 4'h8},
      '{2, 3'b101, 4'h9}, '{2, 3'b111, 4'hA},
      '{2, 3'b111, 4'hB}, '{2, 3'b011, 4'hC},
      '{5, 3'b111, 4'hD}, '{5, 3'b111, 4'hE},
      '{1, 3'b111, 4'hF}, '{1, 3'b111, 4'h0}
    };
    for (int i = 0; i < 16; i++) begin
      cyc(tail[i].c, tail[i].s, tail[i].d);
    end
    repeat (6) cyc(1, 3'b111, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
